// File: rtl/alu_dr_pkg.sv
// -----------------------------------------------------------------------------
// alu_dr_pkg
// Shared definitions for the dual-rail ALU sink: pair codes, rail counts,
// FSM state type, decoded-word struct and a rail-to-word decode helper.
// Optional feature macro used by the importers: ALU_DR_SINK_ERR_CHECK_EN.
// -----------------------------------------------------------------------------
package alu_dr_pkg;

   // Pair code {true, false}
   localparam logic [1:0] DR_SPACER  = 2'b00;
   localparam logic [1:0] DR_ONE     = 2'b10;
   localparam logic [1:0] DR_ZERO    = 2'b01;
   localparam logic [1:0] DR_ILLEGAL = 2'b11;

   localparam int N_SUM_BITS = 4;
   localparam int N_PAIRS    = 7;             // 4 sum + cout + neg + zero
   localparam int N_RAILS    = 2 * N_PAIRS;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic {
      WAIT_DATA   = 1'b0,
      WAIT_SPACER = 1'b1
   } sink_state_t;

   typedef struct packed {
      logic [N_SUM_BITS-1:0] sum;
      logic                  cout;
      logic                  neg;
      logic                  zero;
   } dr_word_t;

   // Rail vector layout (LSB first): sum pairs 0..3, cout, neg, zero.
   // The decoded value of a pair is its true rail (upper bit of the pair).
   function automatic dr_word_t dr_decode(input logic [N_RAILS-1:0] rails);
      dr_word_t w;
      for (int i = 0; i < N_SUM_BITS; i++) w.sum[i] = rails[2*i+1];
      w.cout = rails[2*N_SUM_BITS+1];
      w.neg  = rails[2*N_SUM_BITS+3];
      w.zero = rails[2*N_SUM_BITS+5];
      return w;
   endfunction

endpackage

// File: rtl/alu_dr_sink_sync.sv
// -----------------------------------------------------------------------------
// alu_dr_sync
// Parameterized vector synchronizer: every bit of i_d passes through STAGES
// flops. Synchronous active-high reset clears all stages to 0.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset
//   i_d  - asynchronous input vector (WIDTH bits)
//   o_q  - synchronized output vector (WIDTH bits)
// -----------------------------------------------------------------------------
module alu_dr_sync #(
   parameter int WIDTH  = 14,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_sync;

   // NOTE: clocked state is always updated with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbour.
   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/alu_dr_sink.sv
// -----------------------------------------------------------------------------
// alu_dr_sink
// Synchronous consumer of the asynchronous dual-rail ALU stage. Synchronizes
// the 14 result rails, detects completion / spacer, drives the four-phase
// return-to-zero acknowledge and buffers decoded words in a 2-entry FIFO.
// Build option: define ALU_DR_SINK_ERR_CHECK_EN to treat 11 pairs as
// incomplete and flag them on err; otherwise err is tied 0 and a pair is
// complete when either rail is high.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   soma_dr[7:0]                    - dual-rail sum (pair i = {[2i+1],[2i]})
//   cout_dr, neg_dr, zero_dr [1:0]  - dual-rail flags {true, false}
//   ack_to_stage                    - registered acknowledge to the ALU stage
//   out_valid / out_ready           - FIFO head handshake
//   out_sum, out_cout, out_neg, out_zero - decoded FIFO head
//   err                             - sticky illegal-code flag
// -----------------------------------------------------------------------------
module alu_dr_sink
   import alu_dr_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            soma_dr,
   input  logic [1:0]            cout_dr,
   input  logic [1:0]            neg_dr,
   input  logic [1:0]            zero_dr,
   output logic                  ack_to_stage,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N_SUM_BITS-1:0] out_sum,
   output logic                  out_cout,
   output logic                  out_neg,
   output logic                  out_zero,
   output logic                  err
);

   logic [N_RAILS-1:0] w_sync;
   logic               w_complete;
   logic               w_spacer;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   dr_word_t           w_head;
   sink_state_t        r_state;
   sink_state_t        w_state_nxt;

   dr_word_t           r_mem [FIFO_DEPTH];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;

   alu_dr_sync #(
      .WIDTH  (N_RAILS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d ({zero_dr, neg_dr, cout_dr, soma_dr}),
      .o_q (w_sync)
   );

   // ---------------- completion / spacer / illegal detection ----------------
`ifdef ALU_DR_SINK_ERR_CHECK_EN
   logic w_illegal;
   logic r_err;

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_complete = 1'b1;
      w_illegal  = 1'b0;
      for (int p = 0; p < N_PAIRS; p++) begin
         if (w_sync[2*p +: 2] != DR_ONE && w_sync[2*p +: 2] != DR_ZERO)
            w_complete = 1'b0;
         if (w_sync[2*p +: 2] == DR_ILLEGAL)
            w_illegal = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            r_err <= 1'b0;
      else if (w_illegal) r_err <= 1'b1;
   end

   assign err = r_err;
`else
   always_comb begin
      w_complete = 1'b1;
      for (int p = 0; p < N_PAIRS; p++) begin
         if (w_sync[2*p +: 2] == DR_SPACER) w_complete = 1'b0;
      end
   end

   assign err = 1'b0;
`endif

   assign w_spacer = (w_sync == '0);

   // ---------------- handshake FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= WAIT_DATA;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_DATA:   if (w_push)   w_state_nxt = WAIT_SPACER;
         WAIT_SPACER: if (w_spacer) w_state_nxt = WAIT_DATA;
         default:                   w_state_nxt = WAIT_DATA;
      endcase
   end

   // A full FIFO may still accept a word in the same cycle it pops one.
   always_comb begin
      ack_to_stage = (r_state == WAIT_SPACER);
      w_push       = (r_state == WAIT_DATA) && w_complete && (!w_full || w_pop);
   end

   // ---------------- 2-entry FIFO ----------------
   assign w_full    = (r_count == 2'(DEPTH));
   assign out_valid = (r_count != 2'd0);
   assign w_pop     = out_valid && out_ready;

   // NOTE: the storage is reset as well, so the head outputs read 0 after
   // reset instead of power-up garbage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= dr_decode(w_sync);
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head   = r_mem[r_rd_ptr];
   assign out_sum  = w_head.sum;
   assign out_cout = w_head.cout;
   assign out_neg  = w_head.neg;
   assign out_zero = w_head.zero;

endmodule

// File: tb/tb_alu_dr_sink.sv
// -----------------------------------------------------------------------------
// tb_alu_dr_sink
// Self-checking bench for alu_dr_sink. Acts as the upstream dual-rail stage
// (data / spacer phases driven from the acknowledge) and as the consumer.
// Expected words come from a queue of the words the bench itself encoded.
// -----------------------------------------------------------------------------
module tb_alu_dr_sink;

   localparam int SYNC_STAGES = 2;
   localparam int LAT         = SYNC_STAGES + 1;

   typedef struct {
      logic [3:0] sum;
      logic       cout;
      logic       neg;
      logic       zero;
   } word_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] soma_dr;
   logic [1:0] cout_dr, neg_dr, zero_dr;
   logic       ack_to_stage, out_valid, out_ready;
   logic [3:0] out_sum;
   logic       out_cout, out_neg, out_zero, err;

   int    n_tests = 0;
   int    n_fail  = 0;
   word_t q [$];

   alu_dr_sink #(.SYNC_STAGES(SYNC_STAGES), .DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .soma_dr      (soma_dr),
      .cout_dr      (cout_dr),
      .neg_dr       (neg_dr),
      .zero_dr      (zero_dr),
      .ack_to_stage (ack_to_stage),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_cout     (out_cout),
      .out_neg      (out_neg),
      .out_zero     (out_zero),
      .err          (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   // ---------------- behavioural upstream / model helpers ----------------
   function automatic logic [1:0] enc(input logic b);
      return b ? 2'b10 : 2'b01;
   endfunction

   function automatic word_t rand_word();
      word_t w;
      w.sum  = 4'($urandom_range(0, 15));
      w.cout = 1'($urandom_range(0, 1));
      w.neg  = 1'($urandom_range(0, 1));
      w.zero = 1'($urandom_range(0, 1));
      return w;
   endfunction

   function automatic logic [7:0] head_now();
      return {out_valid, out_sum, out_cout, out_neg, out_zero};
   endfunction

   function automatic logic [7:0] head_exp(input word_t w);
      return {1'b1, w.sum, w.cout, w.neg, w.zero};
   endfunction

   task automatic drive_word(input word_t w);
      for (int i = 0; i < 4; i++) soma_dr[2*i +: 2] = enc(w.sum[i]);
      cout_dr = enc(w.cout);
      neg_dr  = enc(w.neg);
      zero_dr = enc(w.zero);
   endtask

   task automatic drive_spacer();
      soma_dr = '0; cout_dr = '0; neg_dr = '0; zero_dr = '0;
   endtask

   // Counts negedges until ack reaches lvl; -1 when the budget expires.
   task automatic wait_ack(input logic lvl, output int cyc);
      cyc = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (ack_to_stage === lvl) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b0; drive_spacer();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({ack_to_stage, head_now(), err} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_state: got ack/valid/sum/c/n/z/err=%b expected all 0",
                  {ack_to_stage, head_now(), err});
      end
   endtask

   task automatic test_single();
      word_t w;
      int    cyc;
      soma_dr = 8'h99; cout_dr = 2'b01; neg_dr = 2'b10; zero_dr = 2'b01;
      w.sum = 4'hA; w.cout = 1'b0; w.neg = 1'b1; w.zero = 1'b0;
      wait_ack(1'b1, cyc);
      n_tests++;
      if (cyc !== LAT) begin
         n_fail++;
         $display("FAIL single_ack_latency: got %0d cycles expected %0d", cyc, LAT);
      end
      n_tests++;
      if (head_now() !== head_exp(w)) begin
         n_fail++;
         $display("FAIL single_head: got %b expected %b", head_now(), head_exp(w));
      end
   endtask

   task automatic test_spacer();
      int cyc;
      drive_spacer();
      wait_ack(1'b0, cyc);
      n_tests++;
      if (cyc !== LAT) begin
         n_fail++;
         $display("FAIL spacer_ack_fall: got %0d cycles expected %0d", cyc, LAT);
      end
      pop_one();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL spacer_drain: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_random();
      word_t w;
      int    cyc_up, cyc_dn;
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         w = rand_word();
         q.push_back(w);
         drive_word(w);
         wait_ack(1'b1, cyc_up);
         w = q.pop_front();
         n_tests++;
         if (cyc_up !== LAT || head_now() !== head_exp(w)) begin
            n_fail++;
            $display("FAIL random_word%0d: got lat=%0d head=%b expected lat=%0d head=%b",
                     k, cyc_up, head_now(), LAT, head_exp(w));
         end
         drive_spacer();
         wait_ack(1'b0, cyc_dn);
         n_tests++;
         if (cyc_dn !== LAT || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_spacer%0d: got lat=%0d valid=%b expected lat=%0d valid=0",
                     k, cyc_dn, out_valid, LAT);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      word_t w;
      int    cyc;
      logic  held_low = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         w = rand_word();
         q.push_back(w);
         drive_word(w);
         wait_ack(1'b1, cyc);
         n_tests++;
         if (cyc !== LAT) begin
            n_fail++;
            $display("FAIL bp_fill%0d: ack latency got %0d expected %0d", k, cyc, LAT);
         end
         drive_spacer();
         wait_ack(1'b0, cyc);
      end
      w = rand_word();
      q.push_back(w);
      drive_word(w);
      repeat (20) begin
         @(negedge clk);
         if (ack_to_stage !== 1'b0) held_low = 1'b0;
      end
      n_tests++;
      if (held_low !== 1'b1 || head_now() !== head_exp(q[0])) begin
         n_fail++;
         $display("FAIL bp_stall: got ack_low=%b head=%b expected ack_low=1 head=%b",
                  held_low, head_now(), head_exp(q[0]));
      end
      pop_one();
      void'(q.pop_front());
      n_tests++;
      if (ack_to_stage !== 1'b1 || head_now() !== head_exp(q[0])) begin
         n_fail++;
         $display("FAIL bp_capture_on_pop: got ack=%b head=%b expected ack=1 head=%b",
                  ack_to_stage, head_now(), head_exp(q[0]));
      end
      drive_spacer();
      wait_ack(1'b0, cyc);
      while (q.size() > 0) begin
         w = q.pop_front();
         n_tests++;
         if (head_now() !== head_exp(w)) begin
            n_fail++;
            $display("FAIL bp_order: got %b expected %b", head_now(), head_exp(w));
         end
         pop_one();
      end
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_empty: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_partial();
      word_t w;
      int    cyc;
      logic  quiet = 1'b1;
      w = rand_word();
      drive_word(w);
      zero_dr = 2'b00;
      repeat (20) begin
         @(negedge clk);
         if (ack_to_stage !== 1'b0 || out_valid !== 1'b0) quiet = 1'b0;
      end
      n_tests++;
      if (quiet !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_hold: ack/valid rose on incomplete word (quiet=%b expected 1)", quiet);
      end
      zero_dr = enc(w.zero);
      wait_ack(1'b1, cyc);
      n_tests++;
      if (cyc !== LAT || head_now() !== head_exp(w)) begin
         n_fail++;
         $display("FAIL partial_complete: got lat=%0d head=%b expected lat=%0d head=%b",
                  cyc, head_now(), LAT, head_exp(w));
      end
      drive_spacer();
      wait_ack(1'b0, cyc);
      pop_one();
   endtask

   task automatic test_illegal();
      word_t w;
      int    cyc;
      w = rand_word();
      drive_word(w);
      cout_dr = 2'b11;
`ifdef ALU_DR_SINK_ERR_CHECK_EN
      begin
         logic quiet = 1'b1;
         repeat (20) begin
            @(negedge clk);
            if (ack_to_stage !== 1'b0 || out_valid !== 1'b0) quiet = 1'b0;
         end
         n_tests++;
         if (quiet !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_block: got quiet=%b err=%b expected quiet=1 err=1", quiet, err);
         end
         drive_spacer();
         repeat (10) @(negedge clk);
         n_tests++;
         if (err !== 1'b1 || ack_to_stage !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_sticky: got err=%b ack=%b expected err=1 ack=0", err, ack_to_stage);
         end
      end
`else
      w.cout = 1'b1;
      wait_ack(1'b1, cyc);
      n_tests++;
      if (cyc !== LAT || head_now() !== head_exp(w) || err !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_passthru: got lat=%0d head=%b err=%b expected lat=%0d head=%b err=0",
                  cyc, head_now(), err, LAT, head_exp(w));
      end
      drive_spacer();
      wait_ack(1'b0, cyc);
      pop_one();
`endif
   endtask

   task automatic test_reset_mid();
      word_t w;
      int    cyc;
      out_ready = 1'b0;
      w = rand_word();
      drive_word(w);
      wait_ack(1'b1, cyc);
      n_tests++;
      if (cyc !== LAT) begin
         n_fail++;
         $display("FAIL rstmid_enter: ack latency got %0d expected %0d", cyc, LAT);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({ack_to_stage, out_valid, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_clear: got ack/valid/err=%b expected 000",
                  {ack_to_stage, out_valid, err});
      end
      wait_ack(1'b1, cyc);
      n_tests++;
      if (cyc !== LAT || head_now() !== head_exp(w)) begin
         n_fail++;
         $display("FAIL rstmid_recapture: got lat=%0d head=%b expected lat=%0d head=%b",
                  cyc, head_now(), LAT, head_exp(w));
      end
      drive_spacer();
      wait_ack(1'b0, cyc);
      pop_one();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_drain: out_valid got %b expected 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_spacer();
      test_random();
      test_back_to_back();
      test_partial();
      test_illegal();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
